lpc_synth: RTL and testbench
============================

// Module: lpc_synth
// PURPOSE
//   LPC decoder/synthesis stage, directly downstream of the LPC encoder. Takes one frame's predictor
//   coefficients A1..A10, voiced flag and pitch period, generates excitation (impulse train or LFSR
//   noise) and runs a 10th-order all-pole filter, one output sample per input sample strobe.
//   Output feeds the audio DAC path.
// PARAMETERS
//   ORDER      10        predictor order; fixed at 10 in this revision
//   COEF_FRAC  12        fractional bits of coefficients (Q4.12, 4096 = 1.0)
//   ACC_W      40        MAC accumulator width
// PORTS
//   clk         in   1   system clock (single clock domain)
//   rst         in   1   synchronous, active-high reset
//   A1..A10     in   16  signed predictor coefficients, Q4.12
//   voiced      in   1   1 = impulse-train excitation, 0 = noise excitation
//   pitch_per   in   16  pitch period in samples (voiced frames)
//   gain        in   16  unsigned excitation amplitude (<= 32767)
//   load        in   1   1-cycle strobe: capture A1..A10, voiced, pitch_per, gain
//   v           in   1   1-cycle sample strobe; requests one output sample
//   y           out  16  signed synthesized sample
//   vout        out  1   1-cycle pulse, y valid
//   busy        out  1   filter computation in progress
//   overrun     out  1   sticky: v received while busy
// BEHAVIOUR
//   Reset: y=0, vout=0, busy=0, overrun=0, history y[n-1..n-10]=0, coef regs=0, voiced=0,
//     gain=0, pitch_per=0, pitch counter=0, LFSR=16'hACE1, FSM=IDLE.
//   load: frame regs updated next edge; take effect from next v. load coincident with v: the
//     computation started by that v uses OLD values. Pitch counter NOT reset by load.
//   Excitation e[n], evaluated on each accepted v:
//     voiced=1: e=gain when pitch counter==0, else 0; counter increments, wraps to 0 at
//       pitch_per-1. pitch_per==0: e=0 always, counter held at 0. pitch_per==1: impulse every sample.
//     voiced=0: e=(signed(lfsr)*gain)>>>15; LFSR Fibonacci x^16+x^14+x^13+x^11+1, shifts once
//       per accepted v (all modes), value used is pre-shift.
//   Filter: y[n] = sat16( (e<<COEF_FRAC - sum_k A_k*y[n-k]) >>> COEF_FRAC ), arithmetic shift
//     (floor), saturate to [-32768, 32767]. Accumulator ACC_W bits, no intermediate overflow.
//   FSM: IDLE -> (v) LOAD_E: acc=e<<12, k=1 -> MAC: acc-=A_k*hist_k, k++ for k=1..10 (one MAC/clk)
//     -> OUT: y<=sat, shift history, vout=1 -> IDLE.
//   Latency: v at cycle 0 -> vout at cycle 12; busy high cycles 1..12. Min v spacing 13 clk.
//   v while busy (incl. OUT cycle): ignored, no LFSR/pitch advance, overrun<=1 (cleared only by rst).
//   rst mid-computation: abort, all state to reset values, no vout.
//   y holds value between vout pulses.
// STRUCTURE
//   lpc_pkg: ORDER, COEF_FRAC, ACC_W, LFSR_SEED=16'hACE1, LFSR taps, FSM state enum, sat16 function.
//   Sub-module lpc_excitation: pitch counter + LFSR + gain scaling; inputs v_accept, voiced,
//     pitch_per, gain; output signed e. Top holds frame regs, history, single MAC, FSM.
// TESTING
//   Reset: assert rst 2 clk, release -> y=0, vout=0, busy=0, overrun=0; first v w/ gain=0 -> y=0.
//   Impulse train: A=0, voiced=1, pitch_per=4, gain=1000, v every 16 clk -> y=1000,0,0,0,1000,...
//   One-pole: A1=-2048 else 0, voiced=1, pitch_per=0 after one impulse (load pitch_per=100 first,
//     gain=1000) -> y=1000,500,250,125,62,31; vout exactly 12 clk after each v.
//   Saturation: A1=-4096, voiced=1, pitch_per=1, gain=30000 -> y=30000 then 32767 held.
//   Overrun/coincidence: v at t and t+5 -> one vout, overrun=1 sticky; load same cycle as v -> old
//     coefs used for that sample, new coefs next sample.
//   Noise + reset: voiced=0, gain=32767, A=0 -> first y = signed(16'hACE1)*32767>>>15 = -21279;
//     rst asserted mid-MAC -> no vout, next sample repeats -21279 from reseeded LFSR.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared constants, FSM state type and helpers for the LPC synthesis stage.
// Holds the predictor order, Q-format, accumulator width, LFSR seed/taps and sat16.
package lpc_pkg;

   localparam int ORDER     = 10;
   localparam int COEF_FRAC = 12;
   localparam int ACC_W     = 40;
   localparam int E_W       = 18;

   localparam logic [3:0] K_LAST = 4'(ORDER - 1);

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   localparam logic signed [ACC_W-1:0] Y_MAX = 32767;
   localparam logic signed [ACC_W-1:0] Y_MIN = -32768;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD_E,
      S_MAC,
      S_OUT
   } state_t;

   // Drop the Q fraction (floor) and clamp to 16-bit signed.
   function automatic logic [15:0] sat16(
      input logic signed [ACC_W-1:0] a
   );
      logic signed [ACC_W-1:0] s;
      s = a >>> COEF_FRAC;
      if (s > Y_MAX)
         sat16 = 16'h7FFF;
      else if (s < Y_MIN)
         sat16 = 16'h8000;
      else
         sat16 = s[15:0];
   endfunction

   function automatic logic [15:0] lfsr_step(
      input logic [15:0] s
   );
      lfsr_step = {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/lpc_excitation.sv
// Excitation source: pitch-pulse counter, noise LFSR and gain scaling.
// Ports: clk, rst, v_accept (advance), voiced, pitch_per, gain -> e (registered).
module lpc_excitation
   import lpc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  v_accept,
   input  logic                  voiced,
   input  logic [15:0]           pitch_per,
   input  logic [15:0]           gain,
   output logic signed [E_W-1:0] e
);

   logic [15:0]           lfsr_q;
   logic [15:0]           pcnt_q;
   logic [15:0]           pcnt_d;
   logic signed [E_W-1:0] e_q;
   logic signed [E_W-1:0] e_d;
   logic signed [E_W-1:0] e_noise;
   logic signed [32:0]    nprod;

   // Pre-shift LFSR value times gain, floor-scaled by 2^-15
   assign nprod = $signed({{17{lfsr_q[15]}}, lfsr_q})
                * $signed({17'd0, gain});
   assign e_noise = E_W'(nprod >>> 15);

   always_comb begin
      pcnt_d = pcnt_q;
      e_d    = '0;
      if (voiced) begin
         if (pitch_per == 16'd0) begin
            pcnt_d = '0;
         end else begin
            if (pcnt_q == 16'd0)
               e_d = {2'b00, gain};
            // >= also recovers if a new, shorter period was loaded
            if (pcnt_q >= pitch_per - 16'd1)
               pcnt_d = '0;
            else
               pcnt_d = pcnt_q + 16'd1;
         end
      end else begin
         e_d = e_noise;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
         pcnt_q <= '0;
         e_q    <= '0;
      end else if (v_accept) begin
         lfsr_q <= lfsr_step(lfsr_q);
         pcnt_q <= pcnt_d;
         e_q    <= e_d;
      end
   end

   assign e = e_q;

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis: frame regs, 10-tap all-pole filter with one shared MAC.
// Ports: clk, rst, A1..A10, voiced, pitch_per, gain, load, v -> y, vout, busy, overrun.
module lpc_synth
   import lpc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A1,
   input  logic [15:0] A2,
   input  logic [15:0] A3,
   input  logic [15:0] A4,
   input  logic [15:0] A5,
   input  logic [15:0] A6,
   input  logic [15:0] A7,
   input  logic [15:0] A8,
   input  logic [15:0] A9,
   input  logic [15:0] A10,
   input  logic        voiced,
   input  logic [15:0] pitch_per,
   input  logic [15:0] gain,
   input  logic        load,
   input  logic        v,
   output logic [15:0] y,
   output logic        vout,
   output logic        busy,
   output logic        overrun
);

   logic [15:0] a_in   [ORDER];
   logic [15:0] fa_q   [ORDER];
   logic [15:0] wa_q   [ORDER];
   logic [15:0] hist_q [ORDER];

   logic        fvoiced_q;
   logic [15:0] fpitch_q;
   logic [15:0] fgain_q;

   state_t      state_q;
   logic [3:0]  k_q;
   logic [15:0] y_q;
   logic [15:0] y_d;
   logic        vout_q;
   logic        busy_q;
   logic        ovr_q;
   logic        v_acc;

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [31:0]      prod;
   logic signed [E_W-1:0]   e;

   assign a_in[0] = A1;
   assign a_in[1] = A2;
   assign a_in[2] = A3;
   assign a_in[3] = A4;
   assign a_in[4] = A5;
   assign a_in[5] = A6;
   assign a_in[6] = A7;
   assign a_in[7] = A8;
   assign a_in[8] = A9;
   assign a_in[9] = A10;

   assign v_acc = v && (state_q == S_IDLE);

   // Sees the frame regs before a coincident load lands
   lpc_excitation u_exc (
      .clk       (clk),
      .rst       (rst),
      .v_accept  (v_acc),
      .voiced    (fvoiced_q),
      .pitch_per (fpitch_q),
      .gain      (fgain_q),
      .e         (e)
   );

   assign prod = $signed({{16{wa_q[k_q][15]}}, wa_q[k_q]})
               * $signed({{16{hist_q[k_q][15]}}, hist_q[k_q]});
   assign acc_d = acc_q - {{(ACC_W-32){prod[31]}}, prod};
   assign y_d   = sat16(acc_d);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ORDER; i++) begin
            fa_q[i]   <= '0;
            wa_q[i]   <= '0;
            hist_q[i] <= '0;
         end
         fvoiced_q <= 1'b0;
         fpitch_q  <= '0;
         fgain_q   <= '0;
         state_q   <= S_IDLE;
         k_q       <= '0;
         acc_q     <= '0;
         y_q       <= '0;
         vout_q    <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         if (load) begin
            for (int i = 0; i < ORDER; i++)
               fa_q[i] <= a_in[i];
            fvoiced_q <= voiced;
            fpitch_q  <= pitch_per;
            fgain_q   <= gain;
         end

         vout_q <= 1'b0;
         if (v && state_q != S_IDLE)
            ovr_q <= 1'b1;

         unique case (state_q)
            S_IDLE: begin
               if (v) begin
                  // Snapshot coefs so a later load
                  // cannot disturb this sample
                  wa_q    <= fa_q;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD_E;
               end
            end
            S_LOAD_E: begin
               acc_q   <= {{(ACC_W-E_W-COEF_FRAC){e[E_W-1]}},
                           e, {COEF_FRAC{1'b0}}};
               k_q     <= '0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               if (k_q == K_LAST) begin
                  y_q       <= y_d;
                  hist_q[0] <= y_d;
                  for (int i = 1; i < ORDER; i++)
                     hist_q[i] <= hist_q[i-1];
                  vout_q    <= 1'b1;
                  state_q   <= S_OUT;
               end else begin
                  acc_q <= acc_d;
                  k_q   <= k_q + 4'd1;
               end
            end
            S_OUT: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign y       = y_q;
   assign vout    = vout_q;
   assign busy    = busy_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_lpc_synth.sv
// Bench for lpc_synth: directed literal cases plus random traffic
// checked every cycle against a sample-level behavioural model.
module tb_lpc_synth;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] A [10];
   logic        voiced = 1'b0;
   logic [15:0] pitch_per = '0;
   logic [15:0] gain = '0;
   logic        load = 1'b0;
   logic        v = 1'b0;
   logic [15:0] y;
   logic        vout;
   logic        busy;
   logic        overrun;

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   // Model state
   int          m_a [10];
   int          m_hist [10];
   int          m_voiced;
   int          m_pp;
   int          m_gain;
   int          m_pc;
   logic [15:0] m_lfsr;
   bit          acc_valid;
   int          acc_cyc;
   int          acc_y;
   int          prev_y;
   bit          ovr;
   int          ovr_at;

   lpc_synth dut (
      .clk(clk), .rst(rst),
      .A1(A[0]), .A2(A[1]), .A3(A[2]), .A4(A[3]), .A5(A[4]),
      .A6(A[5]), .A7(A[6]), .A8(A[7]), .A9(A[8]), .A10(A[9]),
      .voiced(voiced), .pitch_per(pitch_per), .gain(gain),
      .load(load), .v(v),
      .y(y), .vout(vout), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0d expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   function automatic int sat(longint x);
      if (x > 32767) return 32767;
      if (x < -32768) return -32768;
      return int'(x);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 10; i++) begin
         m_a[i] = 0;
         m_hist[i] = 0;
      end
      m_voiced = 0; m_pp = 0; m_gain = 0; m_pc = 0;
      m_lfsr = 16'hACE1;
      acc_valid = 0; acc_cyc = 0; acc_y = 0; prev_y = 0;
      ovr = 0; ovr_at = 0;
   endtask

   // One sample of the synthesis equation from the frame rules
   task automatic m_sample(output int yv);
      longint e;
      longint acc;
      int s16;
      e = 0;
      if (m_voiced != 0) begin
         if (m_pp == 0) begin
            m_pc = 0;
         end else begin
            if (m_pc == 0) e = m_gain;
            m_pc = (m_pc + 1 >= m_pp) ? 0 : m_pc + 1;
         end
      end else begin
         s16 = int'($signed(m_lfsr));
         e = (longint'(s16) * longint'(m_gain)) >>> 15;
      end
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5],
                m_lfsr[15:1]};
      acc = e * 4096;
      for (int k = 0; k < 10; k++)
         acc -= longint'(m_a[k]) * longint'(m_hist[k]);
      yv = sat(acc >>> 12);
      for (int k = 9; k > 0; k--)
         m_hist[k] = m_hist[k-1];
      m_hist[0] = yv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit dv, bit dl);
      int yv;
      v = dv;
      load = dl;
      if (dv) begin
         if (acc_valid && cyc >= acc_cyc + 1 && cyc <= acc_cyc + 12) begin
            if (!ovr) begin
               ovr = 1;
               ovr_at = cyc + 1;
            end
         end else begin
            if (acc_valid) prev_y = acc_y;
            m_sample(yv);
            acc_y = yv;
            acc_valid = 1;
            acc_cyc = cyc;
         end
      end
      if (dl) begin
         for (int i = 0; i < 10; i++) m_a[i] = int'($signed(A[i]));
         m_voiced = int'(voiced);
         m_pp = int'(pitch_per);
         m_gain = int'(gain);
      end
      tick();
      v = 1'b0;
      load = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_frame(int a1, int vo, int pp, int g);
      for (int i = 0; i < 10; i++) A[i] = '0;
      A[0] = 16'(a1);
      voiced = vo[0];
      pitch_per = 16'(pp);
      gain = 16'(g);
   endtask

   task automatic samp(bit ld, int exp_y);
      int c0;
      int lat;
      c0 = cyc;
      lat = -1;
      drive(1'b1, ld);
      repeat (15) begin
         if (vout && lat < 0) lat = cyc - c0;
         tick();
      end
      chk("latency", lat, 12);
      chk("y_lit", int'($signed(y)), exp_y);
   endtask

   always @(negedge clk) begin
      bit eb;
      bit ev;
      bit eo;
      int ey;
      if (!rst) begin
         eb = acc_valid && cyc >= acc_cyc + 1 && cyc <= acc_cyc + 12;
         ev = acc_valid && cyc == acc_cyc + 12;
         ey = (acc_valid && cyc >= acc_cyc + 12) ? acc_y : prev_y;
         eo = ovr && cyc >= ovr_at;
         chk("vout", int'(vout), int'(ev));
         chk("busy", int'(busy), int'(eb));
         chk("overrun", int'(overrun), int'(eo));
         chk("y", int'($signed(y)), ey);
      end
   end

   initial begin
      int tmp;
      bit ld;
      int gap;
      for (int i = 0; i < 10; i++) A[i] = '0;
      m_reset();
      do_reset();

      chk("rst_y", int'($signed(y)), 0);
      chk("rst_vout", int'(vout), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      samp(1'b0, 0);

      // Impulse train, period 4
      do_reset();
      set_frame(0, 1, 4, 1000);
      drive(1'b0, 1'b1);
      samp(1'b0, 1000);
      samp(1'b0, 0);
      samp(1'b0, 0);
      samp(1'b0, 0);
      samp(1'b0, 1000);
      samp(1'b0, 0);

      // One-pole decay after a single impulse
      do_reset();
      set_frame(-2048, 1, 100, 1000);
      drive(1'b0, 1'b1);
      samp(1'b0, 1000);
      set_frame(-2048, 1, 0, 1000);
      drive(1'b0, 1'b1);
      samp(1'b0, 500);
      samp(1'b0, 250);
      samp(1'b0, 125);
      samp(1'b0, 62);
      samp(1'b0, 31);

      // Saturation
      do_reset();
      set_frame(-4096, 1, 1, 30000);
      drive(1'b0, 1'b1);
      samp(1'b0, 30000);
      samp(1'b0, 32767);
      samp(1'b0, 32767);

      // Overrun and load coincident with v
      do_reset();
      set_frame(0, 1, 1, 1000);
      drive(1'b0, 1'b1);
      drive(1'b1, 1'b0);
      repeat (4) tick();
      drive(1'b1, 1'b0);
      repeat (15) tick();
      chk("ovr_y", int'($signed(y)), 1000);
      chk("ovr_lit", int'(overrun), 1);
      set_frame(-4096, 1, 1, 1000);
      samp(1'b1, 1000);
      samp(1'b0, 2000);
      chk("ovr_sticky", int'(overrun), 1);

      // Noise excitation and reset mid-MAC
      do_reset();
      set_frame(0, 0, 0, 32767);
      drive(1'b0, 1'b1);
      samp(1'b0, -21279);
      drive(1'b1, 1'b0);
      repeat (4) tick();
      do_reset();
      repeat (14) tick();
      set_frame(0, 0, 0, 32767);
      drive(1'b0, 1'b1);
      samp(1'b0, -21279);

      // Random traffic
      do_reset();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            for (int i = 0; i < 10; i++) begin
               tmp = int'($urandom_range(0, 6000)) - 3000;
               A[i] = ($urandom_range(0, 2) == 0) ? 16'(tmp) : 16'd0;
            end
            voiced = 1'($urandom_range(0, 1));
            pitch_per = 16'($urandom_range(0, 6));
            gain = 16'($urandom_range(0, 32767));
         end
         ld = ($urandom_range(0, 3) == 0);
         drive(1'b1, ld);
         gap = int'($urandom_range(0, 16));
         for (int g = 0; g < gap; g++)
            drive(1'b0, $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 40) == 0)
            do_reset();
      end
      repeat (20) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
